// File: rtl/wb_trace_checker_pkg.sv
// Shared types and helpers for the writeback trace checker.
// Holds the FSM state encoding and a width helper that never returns zero.
package wb_trace_checker_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_N_CHECKS = 8;
    localparam int DEF_CYC_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Bits needed to index n items, kept at least 1 so ports never collapse.
    function automatic int wb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_trace_checker_if.sv
// Snoop bundle for the core's MEM/WB register-write port and program counter.
// Master is the core side that drives it; slave is the checker that listens.
interface wb_trace_checker_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Pure observation port: there is no ready. A write is taken on every clock
    // edge where wb_en is high, so the core never stalls for the checker.
    logic [DATA_W-1:0] pc;
    logic              wb_en;
    logic [REG_AW-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;

    modport master (output pc, wb_en, wb_dest, wb_data);
    modport slave  (input  pc, wb_en, wb_dest, wb_data);
endinterface

// File: rtl/wb_trace_checker_shadow_regs.sv
// Shadow register file: one write port with reg 0 write-protected,
// one asynchronous read port and a synchronous clear of the whole file.
module wb_trace_checker_shadow_regs #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] regs [2**REG_AW];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd = regs[ra];
endmodule

// File: rtl/wb_trace_checker.sv
// Writeback monitor: mirrors register writes into a shadow file during a run,
// then walks the expected-value table one entry per cycle and reports the result.
module wb_trace_checker
    import wb_trace_checker_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int N_CHECKS = DEF_N_CHECKS,
    parameter int CYC_W    = DEF_CYC_W,
    parameter int IDX_W    = wb_clog2(N_CHECKS),
    parameter int CNT_W    = wb_clog2(N_CHECKS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CYC_W-1:0]    max_cycles,
    input  logic                stop_pc_en,
    input  logic [DATA_W-1:0]   stop_pc,
    wb_trace_checker_if.slave   wb,
    input  logic                exp_wr,
    input  logic [IDX_W-1:0]    exp_idx,
    input  logic [REG_AW-1:0]   exp_reg,
    input  logic [DATA_W-1:0]   exp_val,
    input  logic                exp_clr,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [IDX_W-1:0]    first_fail,
    output logic [CYC_W-1:0]    cycle_cnt,
    output logic [CYC_W-1:0]    wb_cnt,
    output logic [1:0]          state_dbg
);
    chk_state_t          state;
    logic [N_CHECKS-1:0] exp_valid;
    logic [REG_AW-1:0]   exp_reg_q [N_CHECKS];
    logic [DATA_W-1:0]   exp_val_q [N_CHECKS];
    logic [IDX_W-1:0]    walk_idx;
    logic [DATA_W-1:0]   shadow_rd;
    logic [CYC_W:0]      cyc_plus1;
    logic [CNT_W-1:0]    mis_next;
    logic                idle_like, run_start, run_end, capture, entry_fail, walk_last;

    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
    assign run_start  = start && idle_like;
    // Widened by one bit so a saturated counter cannot wrap into a false match.
    assign cyc_plus1  = {1'b0, cycle_cnt} + (CYC_W+1)'(1);
    assign run_end    = (max_cycles != '0 && cyc_plus1 == {1'b0, max_cycles}) ||
                        (stop_pc_en && wb.pc == stop_pc);
    assign capture    = (state == ST_RUN) && wb.wb_en && wb.wb_dest != '0;
    assign entry_fail = exp_valid[walk_idx] && (shadow_rd != exp_val_q[walk_idx]);
    assign mis_next   = mismatch_cnt + CNT_W'(entry_fail);
    assign walk_last  = (walk_idx == IDX_W'(N_CHECKS - 1));
    assign state_dbg  = state;

    wb_trace_checker_shadow_regs #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_shadow (
        .clk (clk),
        .clr (rst || run_start),
        .we  (capture),
        .wa  (wb.wb_dest),
        .wd  (wb.wb_data),
        .ra  (exp_reg_q[walk_idx]),
        .rd  (shadow_rd)
    );

    // Expected table: writable only while no run is in flight; clear beats write.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_valid <= '0;
        end else if (idle_like) begin
            if (exp_clr) begin
                exp_valid <= '0;
            end else if (exp_wr) begin
                exp_valid[exp_idx] <= 1'b1;
                exp_reg_q[exp_idx] <= exp_reg;
                exp_val_q[exp_idx] <= exp_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            cycle_cnt    <= '0;
            wb_cnt       <= '0;
            walk_idx     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        cycle_cnt    <= '0;
                        wb_cnt       <= '0;
                        walk_idx     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!(&cycle_cnt)) cycle_cnt <= cycle_cnt + CYC_W'(1);
                    if (capture && !(&wb_cnt)) wb_cnt <= wb_cnt + CYC_W'(1);
                    if (run_end) begin
                        state    <= ST_CHECK;
                        walk_idx <= '0;
                    end
                end
                ST_CHECK: begin
                    mismatch_cnt <= mis_next;
                    if (entry_fail && mismatch_cnt == '0) first_fail <= walk_idx;
                    walk_idx <= walk_idx + IDX_W'(1);
                    if (walk_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mis_next == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: budget and stop-PC endings, reg 0
// protection, mid-run reset, ignored controls while busy and counter saturation.
module tb_wb_trace_checker;
    import wb_trace_checker_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, stop_pc_en, exp_wr, exp_clr;
    logic [15:0] max_cycles;
    logic [31:0] stop_pc, exp_val;
    logic [2:0]  exp_idx;
    logic [4:0]  exp_reg;
    logic        busy, done, pass;
    logic [3:0]  mismatch_cnt;
    logic [2:0]  first_fail;
    logic [15:0] cycle_cnt, wb_cnt;
    logic [1:0]  state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int n_wait   = 0;

    wb_trace_checker_if #(.DATA_W(32), .REG_AW(5)) wbi ();

    wb_trace_checker #(.DATA_W(32), .REG_AW(5), .N_CHECKS(8), .CYC_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .max_cycles   (max_cycles),
        .stop_pc_en   (stop_pc_en),
        .stop_pc      (stop_pc),
        .wb           (wbi.slave),
        .exp_wr       (exp_wr),
        .exp_idx      (exp_idx),
        .exp_reg      (exp_reg),
        .exp_val      (exp_val),
        .exp_clr      (exp_clr),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .cycle_cnt    (cycle_cnt),
        .wb_cnt       (wb_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load_entry(input int idx, input int r, input logic [31:0] v);
        exp_wr  = 1'b1;
        exp_idx = 3'(idx);
        exp_reg = 5'(r);
        exp_val = v;
        tick();
        exp_wr  = 1'b0;
    endtask

    task automatic clear_table();
        exp_clr = 1'b1;
        tick();
        exp_clr = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wb_write(input int dest, input logic [31:0] data);
        wbi.wb_en   = 1'b1;
        wbi.wb_dest = 5'(dest);
        wbi.wb_data = data;
        tick();
        wbi.wb_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        n_wait = 0;
        while (!done && n_wait < budget) begin
            tick();
            n_wait++;
        end
        check({tag, "_done_timeout"}, done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop_pc_en = 1'b0; exp_wr = 1'b0; exp_clr = 1'b0;
        max_cycles = '0; stop_pc = '0; exp_val = '0; exp_idx = '0; exp_reg = '0;
        wbi.pc = '0; wbi.wb_en = 1'b0; wbi.wb_dest = '0; wbi.wb_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_mis", mismatch_cnt, 0);
        check("rst_cyc", cycle_cnt, 0);
        check("rst_wbcnt", wb_cnt, 0);
        check("rst_state", state_dbg, ST_IDLE);

        // Case 1: budget of 8 cycles, all entries match.
        load_entry(0, 8, 2);
        load_entry(1, 9, 2);
        load_entry(2, 10, 2);
        load_entry(3, 11, 26);
        load_entry(4, 12, 26);
        max_cycles = 16'd8;
        start_run();
        check("c1_busy", busy, 1);
        check("c1_state_run", state_dbg, ST_RUN);
        wb_write(8, 2);
        wb_write(9, 2);
        wb_write(10, 2);
        wb_write(11, 26);
        wb_write(12, 26);
        wait_done("c1", 40);
        check("c1_done_cycle", cyc - t0, 16);
        check("c1_pass", pass, 1);
        check("c1_mis", mismatch_cnt, 0);
        check("c1_cyc", cycle_cnt, 8);
        check("c1_wbcnt", wb_cnt, 5);
        check("c1_busy_end", busy, 0);

        // Case 2: restart from DONE, reg 11 written with the wrong value.
        start_run();
        check("c2_done_clr", done, 0);
        check("c2_cyc_clr", cycle_cnt, 0);
        wb_write(8, 2);
        wb_write(9, 2);
        wb_write(10, 2);
        wb_write(11, 25);
        wb_write(12, 26);
        wait_done("c2", 40);
        check("c2_pass", pass, 0);
        check("c2_mis", mismatch_cnt, 1);
        check("c2_ff", first_fail, 3);
        check("c2_wbcnt", wb_cnt, 5);

        // Case 3: stop-PC ending with a writeback in the final RUN cycle.
        clear_table();
        load_entry(0, 5, 32'h55);
        load_entry(1, 6, 0);
        max_cycles = '0;
        stop_pc_en = 1'b1;
        stop_pc    = 32'd260;
        wbi.pc     = 32'd228;
        start_run();
        for (int k = 0; k < 20 && state_dbg == ST_RUN; k++) begin
            wbi.pc = 32'(228 + 4 * k);
            if (wbi.pc == 32'd260) wb_write(5, 32'h55);
            else tick();
        end
        check("c3_state_check", state_dbg, ST_CHECK);
        check("c3_cyc", cycle_cnt, 9);
        wait_done("c3", 20);
        check("c3_pass", pass, 1);
        check("c3_wbcnt", wb_cnt, 1);
        stop_pc_en = 1'b0;

        // Case 4: reg 0 writes dropped; clear beats write; table locked while busy.
        exp_clr = 1'b1;
        load_entry(5, 1, 99);
        exp_clr = 1'b0;
        load_entry(2, 0, 0);
        load_entry(0, 3, 7);
        max_cycles = 16'd4;
        start_run();
        wb_write(0, 5);
        exp_wr = 1'b1; exp_idx = 3'd6; exp_reg = 5'd4; exp_val = 32'd77;
        wb_write(3, 7);
        exp_wr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c4_start_ignored", cycle_cnt, 3);
        wait_done("c4", 20);
        check("c4_pass", pass, 1);
        check("c4_mis", mismatch_cnt, 0);
        check("c4_wbcnt", wb_cnt, 1);
        check("c4_cyc", cycle_cnt, 4);

        // Case 5: reset in RUN cycle 4, then an empty-table run.
        max_cycles = 16'd20;
        start_run();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c5_state", state_dbg, ST_IDLE);
        check("c5_done", done, 0);
        check("c5_busy", busy, 0);
        check("c5_cyc", cycle_cnt, 0);
        max_cycles = 16'd3;
        start_run();
        wait_done("c5", 20);
        check("c5_pass", pass, 1);
        check("c5_mis", mismatch_cnt, 0);

        // Case 6: no end condition; counter saturates and the run continues.
        max_cycles = '0;
        start_run();
        for (int k = 0; k < 99; k++) tick();
        start = 1'b1;
        exp_wr = 1'b1; exp_idx = 3'd0; exp_reg = 5'd2; exp_val = 32'd123;
        tick();
        start = 1'b0;
        exp_wr = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        check("c6_cyc_200", cycle_cnt, 200);
        for (int k = 0; k < 65400; k++) tick();
        check("c6_cyc_sat", cycle_cnt, 65535);
        check("c6_busy", busy, 1);
        check("c6_state", state_dbg, ST_RUN);
        check("c6_done", done, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
